scs8hd_parchk_rx: RTL and testbench
===================================

Name: scs8hd_parchk_rx

Overview:
- Serial odd-parity frame receiver and checker. It is the checking end of the 3-input XNOR parity-generator path.
- A transmitter sends DATA_W data bits LSB-first, then one parity bit. Odd parity holds: data ones plus parity bit equals an odd count.
- The block reassembles the word and checks parity. It presents the word on a valid/ready output interface and keeps a saturating parity-error count.
- It sits between a serial link front-end and a parallel consumer in scs8hd-based designs.

Parameters:
- DATA_W, 8, data bits per frame (legal range 2..32).
- ERRCNT_W, 4, width of the saturating parity-error counter.

Ports:
- CLK  input  1  rising-edge clock.
- RESETB  input  1  synchronous active-low reset.
- DIN  input  1  serial data or parity bit; sampled when DIN_VALID=1.
- DIN_VALID  input  1  DIN carries a bit this cycle.
- SOF  input  1  start of frame; qualified by DIN_VALID; marks data bit 0.
- DOUT  output  DATA_W  received data word.
- DOUT_VALID  output  1  DOUT/PERR valid; held until accepted.
- DOUT_READY  input  1  consumer accepts the word.
- PERR  output  1  parity error for the presented word.
- ERRCNT  output  ERRCNT_W  saturating count of frames with a parity error.
- OVERRUN  output  1  sticky flag: a frame start was dropped while a word was held.
- BUSY  output  1  high in SHIFT or PARITY.
- vpwr, vgnd, vpb, vnb  input  1  power pins, present only under SC_USE_PG_PIN.

Behaviour:
- Clocking and reset: one clock, CLK; reset is synchronous and active-low, RESETB. All state updates on the rising edge of CLK.
- Reset (RESETB=0 at an edge), which overrides everything, including mid-frame:
  - state goes to IDLE;
  - DOUT=0, DOUT_VALID=0, PERR=0, ERRCNT=0, OVERRUN=0, BUSY=0;
  - the partial frame is discarded.
- A bit is "accepted" when DIN_VALID=1 at the edge. Cycles with DIN_VALID=0 are stalls and change no state.
- IDLE:
  - DIN_VALID & SOF: shift[0]<=DIN, bitcnt<=1, par<=DIN, go to SHIFT.
  - DIN_VALID without SOF: ignored.
- SHIFT:
  - Each accepted bit: shift[bitcnt]<=DIN, par<=par^DIN, bitcnt++.
  - When bitcnt reaches DATA_W, go to PARITY.
  - DIN_VALID & SOF mid-frame: abort the current frame and restart with DIN as bit 0. No output, no error count.
- PARITY:
  - The next accepted bit is the parity bit p.
  - PERR<=~(par^p), i.e. an error when the total ones count is even.
  - DOUT<=shift, DOUT_VALID<=1, go to HOLD.
  - ERRCNT increments if PERR, saturating at all-ones.
  - DIN_VALID & SOF in PARITY aborts and restarts, as in SHIFT.
- HOLD:
  - DOUT, PERR and DOUT_VALID stay stable until DOUT_VALID & DOUT_READY at an edge.
  - On transfer: DOUT_VALID<=0 and go to IDLE.
  - Same-edge new frame: if DIN_VALID & SOF coincide with the transfer edge, go directly to SHIFT with DIN as bit 0 (back-to-back, no lost bit).
  - DIN_VALID & SOF without DOUT_READY: the bit is dropped, OVERRUN<=1 (sticky until reset), state stays HOLD. Later bits of that frame are ignored until the next SOF accepted from IDLE.
- Latency: DOUT_VALID rises on the edge that accepts the parity bit. It is visible the cycle after the parity bit is presented.
- Throughput: 1 frame per DATA_W+1 accepted bits when DOUT_READY is held high.
- DOUT_READY while DOUT_VALID=0 has no effect.
- BUSY = (state==SHIFT)|(state==PARITY), registered.
- bitcnt width is clog2(DATA_W+1).

Test Plan:
- Good frame, DATA_W=8: SOF with bits of 0xA5 LSB-first (1,0,1,0,0,1,0,1), then p=1, DOUT_READY=1 -> DOUT_VALID=1 for 1 cycle, DOUT=0xA5, PERR=0, ERRCNT=0.
- Bad parity: 0xA5 then p=0 -> DOUT=0xA5, PERR=1, ERRCNT=1.
- Saturation: 17 consecutive bad frames (0x00, p=0) -> ERRCNT=15 after frame 15, stays 15 after frames 16 and 17.
- Mid-frame abort and stalls: SOF then 3 bits, SOF again, then frame 0x3C with p=1, DIN_VALID gapped every other cycle -> exactly one DOUT_VALID, DOUT=0x3C, PERR=0, ERRCNT unchanged.
- Overrun: complete 0x81 (p=1), hold DOUT_READY=0 for 12 cycles while a new SOF frame arrives -> DOUT stays 0x81, OVERRUN=1. Raising DOUT_READY gives one transfer, then IDLE.
- Reset mid-operation: RESETB=0 for one edge after 4 bits of a frame -> next cycle all outputs at reset values. A following full frame 0x5A with p=1 -> DOUT=0x5A, PERR=0.

Source files
------------

// File: rtl/scs8hd_parchk_rx.sv
// rtl/scs8hd_parchk_rx.sv - serial odd-parity frame receiver with valid/ready word output
// Reassembles DATA_W LSB-first data bits plus one parity bit, checks odd
// parity, holds the word until the consumer takes it and counts bad frames.
module scs8hd_parchk_rx #(
   parameter int DATA_W   = 8,
   parameter int ERRCNT_W = 4
) (
`ifdef SC_USE_PG_PIN
   input  logic                vpwr,
   input  logic                vgnd,
   input  logic                vpb,
   input  logic                vnb,
`endif
   input  logic                CLK,
   input  logic                RESETB,
   input  logic                DIN,
   input  logic                DIN_VALID,
   input  logic                SOF,
   output logic [DATA_W-1:0]   DOUT,
   output logic                DOUT_VALID,
   input  logic                DOUT_READY,
   output logic                PERR,
   output logic [ERRCNT_W-1:0] ERRCNT,
   output logic                OVERRUN,
   output logic                BUSY
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, HOLD} state_t;

   state_t            state;
   logic [DATA_W-1:0] shift_q;
   logic [CNT_W-1:0]  bitcnt;
   logic              par;
   logic              sof_bit;
   logic              start;
   logic              bad_par;

   // A frame start is taken everywhere except when a word is still held
   // and the consumer is not taking it on this same edge.
   assign sof_bit = DIN_VALID & SOF;
   assign start   = sof_bit & ((state != HOLD) | DOUT_READY);
   // Odd parity: an even total ones count is an error.
   assign bad_par = ~(par ^ DIN);

   // Frame state machine with registered outputs. Bits enter at the top
   // and move down, so after DATA_W shifts bit 0 sits at the LSB.
   always_ff @(posedge CLK) begin
      if (!RESETB) begin
         state      <= IDLE;
         shift_q    <= '0;
         bitcnt     <= '0;
         par        <= 1'b0;
         DOUT       <= '0;
         DOUT_VALID <= 1'b0;
         PERR       <= 1'b0;
         ERRCNT     <= '0;
         OVERRUN    <= 1'b0;
         BUSY       <= 1'b0;
      end else begin
         if ((state == HOLD) && DOUT_READY) begin
            DOUT_VALID <= 1'b0;
         end
         if ((state == HOLD) && !DOUT_READY && sof_bit) begin
            OVERRUN <= 1'b1;
         end
         if (start) begin
            shift_q <= {DIN, shift_q[DATA_W-1:1]};
            bitcnt  <= CNT_W'(1);
            par     <= DIN;
            state   <= SHIFT;
            BUSY    <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  BUSY <= 1'b0;
               end
               SHIFT: begin
                  if (DIN_VALID) begin
                     shift_q <= {DIN, shift_q[DATA_W-1:1]};
                     par     <= par ^ DIN;
                     bitcnt  <= bitcnt + 1'b1;
                     if (bitcnt == LAST_BIT) begin
                        state <= PARITY;
                     end
                  end
               end
               PARITY: begin
                  if (DIN_VALID) begin
                     DOUT       <= shift_q;
                     DOUT_VALID <= 1'b1;
                     PERR       <= bad_par;
                     if (bad_par && (ERRCNT != '1)) begin
                        ERRCNT <= ERRCNT + 1'b1;
                     end
                     state <= HOLD;
                     BUSY  <= 1'b0;
                  end
               end
               HOLD: begin
                  if (DOUT_READY) begin
                     state <= IDLE;
                  end
               end
               default: begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scs8hd_parchk_rx.sv
// tb/tb_scs8hd_parchk_rx.sv - directed self-checking bench for scs8hd_parchk_rx
module tb_scs8hd_parchk_rx;

   logic       CLK = 1'b0;
   logic       RESETB;
   logic       DIN;
   logic       DIN_VALID;
   logic       SOF;
   logic [7:0] DOUT;
   logic       DOUT_VALID;
   logic       DOUT_READY;
   logic       PERR;
   logic [3:0] ERRCNT;
   logic       OVERRUN;
   logic       BUSY;

   int n_cmp  = 0;
   int n_fail = 0;
   int xfer_cnt = 0;

   scs8hd_parchk_rx #(.DATA_W(8), .ERRCNT_W(4)) dut (
      .CLK        (CLK),
      .RESETB     (RESETB),
      .DIN        (DIN),
      .DIN_VALID  (DIN_VALID),
      .SOF        (SOF),
      .DOUT       (DOUT),
      .DOUT_VALID (DOUT_VALID),
      .DOUT_READY (DOUT_READY),
      .PERR       (PERR),
      .ERRCNT     (ERRCNT),
      .OVERRUN    (OVERRUN),
      .BUSY       (BUSY)
   );

   always #5 CLK = ~CLK;

   // count word transfers as seen at the active edge
   always @(posedge CLK) begin
      if (RESETB && DOUT_VALID && DOUT_READY) xfer_cnt = xfer_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (got !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge CLK);
   endtask

   task automatic send_bit(input logic b, input logic s);
      DIN = b; SOF = s; DIN_VALID = 1'b1;
      tick();
      DIN_VALID = 1'b0; SOF = 1'b0; DIN = 1'b0;
   endtask

   // 8 data bits LSB-first then parity; returns at the negedge after the parity edge
   task automatic send_frame(input logic [7:0] d, input logic p, input bit gap);
      for (int i = 0; i < 8; i++) begin
         send_bit(d[i], i == 0);
         if (gap) tick();
      end
      send_bit(p, 1'b0);
   endtask

   task automatic do_reset();
      RESETB = 1'b0;
      tick();
      RESETB = 1'b1;
   endtask

   task automatic check_reset_vals(input string pfx);
      check({pfx, "_dout"},    DOUT, 8'h00);
      check({pfx, "_valid"},   DOUT_VALID, 0);
      check({pfx, "_perr"},    PERR, 0);
      check({pfx, "_errcnt"},  ERRCNT, 0);
      check({pfx, "_overrun"}, OVERRUN, 0);
      check({pfx, "_busy"},    BUSY, 0);
   endtask

   initial begin
      RESETB = 1'b0; DIN = 1'b0; DIN_VALID = 1'b0; SOF = 1'b0; DOUT_READY = 1'b1;
      tick(); tick();
      RESETB = 1'b1;
      check_reset_vals("rst0");

      // good frame 0xA5, four ones, p=1
      xfer_cnt = 0;
      send_frame(8'hA5, 1'b1, 1'b0);
      check("good_valid", DOUT_VALID, 1);
      check("good_dout",  DOUT, 8'hA5);
      check("good_perr",  PERR, 0);
      check("good_errcnt", ERRCNT, 0);
      tick();
      check("good_valid_1cyc", DOUT_VALID, 0);
      check("good_xfer", xfer_cnt, 1);
      tick();

      // bad parity 0xA5, p=0
      send_frame(8'hA5, 1'b0, 1'b0);
      check("bad_dout",   DOUT, 8'hA5);
      check("bad_perr",   PERR, 1);
      check("bad_errcnt", ERRCNT, 1);
      tick();

      // saturation from zero
      do_reset();
      for (int f = 1; f <= 17; f++) begin
         send_frame(8'h00, 1'b0, 1'b0);
         check($sformatf("sat_errcnt_f%0d", f), ERRCNT, (f > 15) ? 15 : f);
      end
      check("sat_perr", PERR, 1);
      tick(); tick();

      // mid-frame abort, then gapped 0x3C (four ones, p=1)
      xfer_cnt = 0;
      send_bit(1'b1, 1'b1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      check("abort_busy", BUSY, 1);
      send_frame(8'h3C, 1'b1, 1'b1);
      check("abort_valid", DOUT_VALID, 1);
      check("abort_dout",  DOUT, 8'h3C);
      check("abort_perr",  PERR, 0);
      check("abort_errcnt", ERRCNT, 15);
      tick(); tick(); tick();
      check("abort_xfer", xfer_cnt, 1);

      // overrun: hold 0x81 (two ones, p=1) while another frame arrives
      DOUT_READY = 1'b0;
      xfer_cnt = 0;
      send_frame(8'h81, 1'b1, 1'b0);
      check("ovr_valid0", DOUT_VALID, 1);
      check("ovr_dout0",  DOUT, 8'h81);
      check("ovr_flag0",  OVERRUN, 0);
      send_frame(8'h55, 1'b0, 1'b0);
      tick(); tick(); tick();
      check("ovr_valid",  DOUT_VALID, 1);
      check("ovr_dout",   DOUT, 8'h81);
      check("ovr_perr",   PERR, 0);
      check("ovr_flag",   OVERRUN, 1);
      check("ovr_busy",   BUSY, 0);
      check("ovr_noxfer", xfer_cnt, 0);
      DOUT_READY = 1'b1;
      tick();
      check("ovr_valid_drop", DOUT_VALID, 0);
      tick(); tick();
      check("ovr_xfer", xfer_cnt, 1);
      check("ovr_idle_busy", BUSY, 0);
      check("ovr_sticky", OVERRUN, 1);

      // reset after 4 bits of a frame
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      check("mid_busy", BUSY, 1);
      do_reset();
      check_reset_vals("rst1");
      send_frame(8'h5A, 1'b1, 1'b0);
      check("post_valid", DOUT_VALID, 1);
      check("post_dout",  DOUT, 8'h5A);
      check("post_perr",  PERR, 0);
      check("post_errcnt", ERRCNT, 0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
